// File: rtl/spiker_writer.sv
// rtl/spiker_writer.sv - packs the spike nibble stream into words and issues one write per word
module spiker_writer #(
   parameter int WIDTH  = 32,
   parameter int NIB    = 4,
   parameter int N_BITS = 784,
   parameter int N_REG  = 25,
   parameter int IDX_W  = $clog2(N_REG)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             test_mode_i,
   input  logic             start_i,
   input  logic             sample_i,
   input  logic [NIB-1:0]   nibble_i,
   output logic             wr_en_o,
   output logic [IDX_W-1:0] wr_idx_o,
   output logic [WIDTH-1:0] wr_data_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             overflow_o
);

   localparam int NPW   = WIDTH / NIB;
   localparam int NTOT  = N_BITS / NIB;
   localparam int NW_W  = (NPW > 1) ? $clog2(NPW) : 1;
   localparam int TOT_W = $clog2(NTOT + 1);

   localparam logic [NW_W-1:0]  NIB_LAST = NW_W'(NPW - 1);
   localparam logic [TOT_W-1:0] TOT_LAST = TOT_W'(NTOT - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

   state_t             state_q, state_d;
   logic [NW_W-1:0]    nib_cnt_q, nib_cnt_d;
   logic [TOT_W-1:0]   tot_cnt_q, tot_cnt_d;
   logic [IDX_W-1:0]   word_cnt_q, word_cnt_d;
   logic [WIDTH-1:0]   buf_q, buf_d;
   logic               wr_en_q, wr_en_d;
   logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
   logic [WIDTH-1:0]   wr_data_q, wr_data_d;
   logic               overflow_q, overflow_d;
   logic [WIDTH-1:0]   word_fill;

   // test_mode_i has no function here; kept on the port list for DFT uniformity
   logic unused_test_mode;
   assign unused_test_mode = test_mode_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         nib_cnt_q  <= '0;
         tot_cnt_q  <= '0;
         word_cnt_q <= '0;
         buf_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_idx_q   <= '0;
         wr_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         nib_cnt_q  <= nib_cnt_d;
         tot_cnt_q  <= tot_cnt_d;
         word_cnt_q <= word_cnt_d;
         buf_q      <= buf_d;
         wr_en_q    <= wr_en_d;
         wr_idx_q   <= wr_idx_d;
         wr_data_q  <= wr_data_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      word_fill = buf_q;
      word_fill[nib_cnt_q*NIB +: NIB] = nibble_i;
   end

   always_comb begin
      state_d    = state_q;
      nib_cnt_d  = nib_cnt_q;
      tot_cnt_d  = tot_cnt_q;
      word_cnt_d = word_cnt_q;
      buf_d      = buf_q;
      wr_en_d    = 1'b0;
      wr_idx_d   = wr_idx_q;
      wr_data_d  = wr_data_q;
      overflow_d = overflow_q;

      if (start_i) begin
         // start wins over a coincident sample; any partial word is discarded
         state_d    = COLLECT;
         nib_cnt_d  = '0;
         tot_cnt_d  = '0;
         word_cnt_d = '0;
         buf_d      = '0;
         overflow_d = 1'b0;
      end else begin
         unique case (state_q)
            COLLECT: begin
               if (sample_i) begin
                  tot_cnt_d = tot_cnt_q + 1'b1;
                  if (nib_cnt_q == NIB_LAST || tot_cnt_q == TOT_LAST) begin
                     wr_en_d    = 1'b1;
                     wr_data_d  = word_fill;
                     wr_idx_d   = word_cnt_q;
                     word_cnt_d = word_cnt_q + 1'b1;
                     buf_d      = '0;
                     nib_cnt_d  = '0;
                  end else begin
                     buf_d     = word_fill;
                     nib_cnt_d = nib_cnt_q + 1'b1;
                  end
                  if (tot_cnt_q == TOT_LAST) state_d = DONE;
               end
            end
            DONE: begin
               if (sample_i) overflow_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign wr_en_o    = wr_en_q;
   assign wr_idx_o   = wr_idx_q;
   assign wr_data_o  = wr_data_q;
   assign busy_o     = (state_q == COLLECT);
   assign done_o     = (state_q == DONE);
   assign overflow_o = overflow_q;

endmodule

// File: tb/tb_spiker_writer.sv
// tb/tb_spiker_writer.sv - directed self-checking bench for spiker_writer
module tb_spiker_writer;

   logic        clk;
   logic        rst_n;
   logic        test_mode;
   logic        start;
   logic        sample;
   logic [3:0]  nibble;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        overflow;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int          w_idx[$];
   logic [31:0] w_data[$];
   int          w_cyc[$];
   logic        w_done[$];
   logic        w_busy[$];

   spiker_writer dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .test_mode_i (test_mode),
      .start_i     (start),
      .sample_i    (sample),
      .nibble_i    (nibble),
      .wr_en_o     (wr_en),
      .wr_idx_o    (wr_idx),
      .wr_data_o   (wr_data),
      .busy_o      (busy),
      .done_o      (done),
      .overflow_o  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         w_idx.push_back(int'(wr_idx));
         w_data.push_back(wr_data);
         w_cyc.push_back(cyc);
         w_done.push_back(done);
         w_busy.push_back(busy);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      w_idx.delete();
      w_data.delete();
      w_cyc.delete();
      w_done.delete();
      w_busy.delete();
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [3:0] v);
      sample = 1'b1;
      nibble = v;
      tick();
      sample = 1'b0;
   endtask

   function automatic logic [31:0] frame_word(input int k);
      if (k == 24) return 32'h0000_3210;
      return (k % 2 == 0) ? 32'h7654_3210 : 32'hFEDC_BA98;
   endfunction

   task automatic check_frame(input string tag, input int start_cyc, input bit timing);
      checks++;
      if (w_idx.size() !== 25) begin
         errors++;
         $display("FAIL %s_count: got %0d writes, expected 25", tag, w_idx.size());
      end
      for (int k = 0; k < 25 && k < w_idx.size(); k++) begin
         checks++;
         if (w_idx[k] !== k || w_data[k] !== frame_word(k)) begin
            errors++;
            $display("FAIL %s_word%0d: got idx=%0d data=%08h, expected idx=%0d data=%08h",
                     tag, k, w_idx[k], w_data[k], k, frame_word(k));
         end
         if (timing) begin
            checks++;
            if (w_cyc[k] !== ((k == 24) ? start_cyc + 196 : start_cyc + 8*k + 8)) begin
               errors++;
               $display("FAIL %s_lat%0d: got cycle %0d, expected %0d", tag, k, w_cyc[k],
                        (k == 24) ? start_cyc + 196 : start_cyc + 8*k + 8);
            end
            checks++;
            if (w_done[k] !== (k == 24) || w_busy[k] !== (k != 24)) begin
               errors++;
               $display("FAIL %s_flags%0d: got done=%0b busy=%0b, expected done=%0b busy=%0b",
                        tag, k, w_done[k], w_busy[k], k == 24, k != 24);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({wr_en, wr_idx, wr_data, busy, done, overflow} !== 41'd0) begin
         errors++;
         $display("FAIL reset_outputs: got en=%0b idx=%0d data=%08h busy=%0b done=%0b ovf=%0b, expected all 0",
                  wr_en, wr_idx, wr_data, busy, done, overflow);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      clear_log();
      for (int i = 0; i < 5; i++) send(4'hA);
      tick();
      checks++;
      if (w_idx.size() !== 0 || overflow !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_sample: got writes=%0d ovf=%0b busy=%0b, expected 0 0 0",
                  w_idx.size(), overflow, busy);
      end
   endtask

   task automatic test_back_to_back();
      int sc;
      clear_log();
      do_start();
      sc = cyc;
      for (int i = 0; i < 196; i++) send(4'(i % 16));
      tick();
      tick();
      check_frame("b2b", sc, 1'b1);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: got done=%0b busy=%0b, expected 1 0", done, busy);
      end
   endtask

   task automatic test_gaps();
      clear_log();
      do_start();
      for (int i = 0; i < 196; i++) begin
         int g = $urandom_range(0, 3);
         for (int j = 0; j < g; j++) tick();
         send(4'(i % 16));
      end
      tick();
      tick();
      check_frame("gap", 0, 1'b0);
   endtask

   task automatic test_overflow();
      clear_log();
      send(4'h5);
      tick();
      checks++;
      if (overflow !== 1'b1 || w_idx.size() !== 0 || done !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got ovf=%0b writes=%0d done=%0b, expected 1 0 1",
                  overflow, w_idx.size(), done);
      end
      do_start();
      checks++;
      if (overflow !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ovf_clear: got ovf=%0b done=%0b busy=%0b, expected 0 0 1",
                  overflow, done, busy);
      end
   endtask

   task automatic test_abort();
      clear_log();
      do_start();
      for (int i = 0; i < 13; i++) send(4'hF);
      tick();
      checks++;
      if (w_idx.size() !== 1 || w_data[0] !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL abort_first: got writes=%0d, expected 1 write of FFFFFFFF", w_idx.size());
      end
      clear_log();
      do_start();
      tick();
      checks++;
      if (w_idx.size() !== 0) begin
         errors++;
         $display("FAIL abort_partial: got %0d writes, expected 0", w_idx.size());
      end
      for (int i = 0; i < 8; i++) send(4'h1);
      tick();
      checks++;
      if (w_idx.size() !== 1 || w_idx[0] !== 0 || w_data[0] !== 32'h1111_1111) begin
         errors++;
         $display("FAIL abort_fresh: got writes=%0d idx=%0d data=%08h, expected 1 0 11111111",
                  w_idx.size(), (w_idx.size() > 0) ? w_idx[0] : -1,
                  (w_data.size() > 0) ? w_data[0] : 32'h0);
      end
   endtask

   task automatic test_start_sample();
      clear_log();
      start = 1'b1;
      sample = 1'b1;
      nibble = 4'hF;
      tick();
      start = 1'b0;
      sample = 1'b0;
      checks++;
      if (overflow !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL start_sample_flags: got ovf=%0b busy=%0b, expected 0 1", overflow, busy);
      end
      for (int i = 1; i <= 8; i++) send(4'(i));
      tick();
      checks++;
      if (w_idx.size() !== 1 || w_data[0] !== 32'h8765_4321) begin
         errors++;
         $display("FAIL start_sample_word: got writes=%0d data=%08h, expected 1 87654321",
                  w_idx.size(), (w_data.size() > 0) ? w_data[0] : 32'h0);
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      for (int i = 0; i < 3; i++) send(4'h9);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_en, wr_idx, wr_data, busy, done, overflow} !== 41'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got en=%0b idx=%0d data=%08h busy=%0b done=%0b ovf=%0b, expected all 0",
                  wr_en, wr_idx, wr_data, busy, done, overflow);
      end
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) send(4'h3);
      tick();
      checks++;
      if (w_idx.size() !== 0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_idle: got writes=%0d busy=%0b done=%0b, expected 0 0 0",
                  w_idx.size(), busy, done);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_mode = 1'b0;
      start = 1'b0;
      sample = 1'b0;
      nibble = 4'h0;
      test_reset();
      test_back_to_back();
      test_gaps();
      test_overflow();
      test_abort();
      test_start_sample();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
